// File: rtl/bexkat1_pkg.sv
// bexkat1 shared fetch definitions.
// Widths, IR encoding helpers and fetch FSM states.
package bexkat1_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IR_W = 64;
  localparam int unsigned INSN_LONG_BIT = 0;
  localparam logic [IR_W-1:0] IR_NOP = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_e;

  function automatic logic insn_is_long(
    input logic [WORD_W-1:0] w
  );
    return w[INSN_LONG_BIT];
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Word FIFO for the instruction prefetcher.
// Exposes the two oldest words so a long insn can pop both at once.
module prefetch_fifo
  import bexkat1_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              pop1_i,
  input  logic              pop2_i,
  output logic [CW-1:0]     count_o,
  output logic [WORD_W-1:0] head0_o,
  output logic [WORD_W-1:0] head1_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_nx;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     npop;

  assign rd_nx = rd_q + AW'(1);
  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[rd_nx];
  assign count_o = cnt_q;
  assign npop = pop2_i ? CW'(2) :
                pop1_i ? CW'(1) : '0;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= wr_q + AW'(1);
      end
      rd_q  <= rd_q + npop[AW-1:0];
      cnt_q <= cnt_q + CW'(push_i) - npop;
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// bexkat1 instruction prefetch queue.
// Wishbone word reads into a FIFO, assembled into a 64-bit IR.
module ifetch_prefetch
  import bexkat1_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              pc_set,
  input  logic [WORD_W-1:0] pc_in,
  output logic [IR_W-1:0]   ir,
  output logic [WORD_W-1:0] pc,
  output logic              valid,
  output logic              bus_cyc,
  output logic [WORD_W-1:0] bus_adr,
  input  logic              bus_ack,
  input  logic [WORD_W-1:0] bus_in
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      st_q;
  logic [WORD_W-1:0] fetch_adr_q;
  logic [WORD_W-1:0] bus_adr_q;
  logic [WORD_W-1:0] head_pc_q;
  logic [WORD_W-1:0] pc_q;
  logic [IR_W-1:0]   ir_q;
  logic              valid_q;

  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] head0;
  logic [WORD_W-1:0] head1;
  logic [WORD_W-1:0] tgt;
  logic              is_long;
  logic              ready;
  logic              ld;
  logic              push;
  logic              pop1;
  logic              pop2;

  assign tgt = pc_in & ~32'h3;
  assign is_long = insn_is_long(head0);
  assign ready = (cnt != '0) &&
                 (!is_long || cnt >= CW'(2));
  assign ld = !pc_set && (!valid_q || !stall_i) && ready;
  assign pop1 = ld && !is_long;
  assign pop2 = ld && is_long;
  assign push = bus_ack && (st_q == REQ) && !pc_set;

  assign ir = ir_q;
  assign pc = pc_q;
  assign valid = valid_q;
  assign bus_cyc = (st_q != IDLE);
  assign bus_adr = bus_adr_q;

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .flush_i(pc_set),
    .push_i (push),
    .wdata_i(bus_in),
    .pop1_i (pop1),
    .pop2_i (pop2),
    .count_o(cnt),
    .head0_o(head0),
    .head1_o(head1)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q        <= IDLE;
      fetch_adr_q <= RESET_PC;
      bus_adr_q   <= RESET_PC;
      head_pc_q   <= RESET_PC;
      pc_q        <= RESET_PC;
      ir_q        <= IR_NOP;
      valid_q     <= 1'b0;
    end else if (pc_set) begin
      fetch_adr_q <= tgt;
      head_pc_q   <= tgt;
      ir_q        <= IR_NOP;
      valid_q     <= 1'b0;
      // an in-flight read must finish; its data is owed to nobody
      unique case (st_q)
        IDLE: begin
          st_q      <= REQ;
          bus_adr_q <= tgt;
        end
        default: st_q <= bus_ack ? IDLE : DISCARD;
      endcase
    end else begin
      if (!valid_q || !stall_i) begin
        if (ready) begin
          ir_q      <= is_long ? {head1, head0}
                               : {32'h0, head0};
          pc_q      <= head_pc_q;
          head_pc_q <= head_pc_q +
                       (is_long ? 32'd8 : 32'd4);
          valid_q   <= 1'b1;
        end else begin
          ir_q    <= IR_NOP;
          valid_q <= 1'b0;
        end
      end
      unique case (st_q)
        IDLE: begin
          if (cnt < CW'(DEPTH)) begin
            st_q      <= REQ;
            bus_adr_q <= fetch_adr_q;
          end
        end
        REQ: begin
          if (bus_ack) begin
            st_q        <= IDLE;
            fetch_adr_q <= fetch_adr_q + 32'd4;
          end
        end
        DISCARD: begin
          if (bus_ack) begin
            st_q <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch.
// Directed vectors; a monitor pops expected IR/PC on every load.
module tb_ifetch_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        pc_set = 1'b0;
  logic [31:0] pc_in = '0;
  logic [63:0] ir;
  logic [31:0] pc;
  logic        valid;
  logic        bus_cyc;
  logic [31:0] bus_adr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_in = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] acks[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] slow_adr = 32'hFFFF_FFF0;
  int          slow_lat = 0;
  int          wcnt = 0;

  ifetch_prefetch #(
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .stall_i(stall_i),
    .pc_set (pc_set),
    .pc_in  (pc_in),
    .ir     (ir),
    .pc     (pc),
    .valid  (valid),
    .bus_cyc(bus_cyc),
    .bus_adr(bus_adr),
    .bus_ack(bus_ack),
    .bus_in (bus_in)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | a;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    if (i < acks.size()) return acks[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p,
                      input logic [63:0] i);
    sb_q.push_back(exp_t'{pc: p, ir: i});
  endtask

  task automatic push_s(input logic [31:0] p);
    push(p, {32'h0, rd(p)});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic hold_reset();
    rst_i = 1'b0;
    stall_i = 1'b0;
    pc_set = 1'b0;
    slow_adr = 32'hFFFF_FFF0;
    slow_lat = 0;
    mem.delete();
    tick();
    tick();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(nm, 64'(sb_q.size()), 64'h0);
    sb_q.delete();
  endtask

  // wishbone slave: ack after a per-address wait
  always @(negedge clk_i) begin
    if (bus_cyc && !bus_ack) begin
      if (wcnt >= ((bus_adr == slow_adr) ? slow_lat : 0)) begin
        bus_ack = 1'b1;
        bus_in = rd(bus_adr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      bus_ack = 1'b0;
      bus_in = '0;
      wcnt = 0;
    end
  end

  always @(posedge clk_i) begin
    if (rst_i && bus_cyc && bus_ack) acks.push_back(bus_adr);
  end

  always @(posedge clk_i) begin
    logic        st;
    logic        vb;
    logic        rb;
    logic [63:0] pir;
    logic [31:0] ppc;
    exp_t        e;
    st = stall_i;
    vb = valid;
    rb = rst_i;
    pir = ir;
    ppc = pc;
    #1;
    if (rb && rst_i && valid) begin
      if (!vb || !st) begin
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_pc", 64'(pc), 64'(e.pc));
          chk("sb_ir", ir, e.ir);
        end
      end else begin
        chk("hold_ir", ir, pir);
        chk("hold_pc", 64'(pc), 64'(ppc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int i0;
    hold_reset();
    chk("rst_ir", ir, 64'h0);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_cyc", 64'(bus_cyc), 64'h0);

    // basic stream with a long insn at 0x04
    mem[32'h0] = 32'h1000_0000;
    mem[32'h4] = 32'h1000_0001;
    mem[32'h8] = 32'hDEAD_BEEF;
    push(32'h0, 64'h0000_0000_1000_0000);
    push(32'h4, 64'hDEAD_BEEF_1000_0001);
    push(32'hC, 64'h0000_0000_A000_000C);
    push(32'h10, 64'h0000_0000_A000_0010);
    rst_i = 1'b1;
    drain("t1_drain");

    // stall after the first valid fills the FIFO
    hold_reset();
    for (int k = 0; k < 8; k++) push_s(32'(k * 4));
    rst_i = 1'b1;
    n = 0;
    while (!valid && n < 20) begin tick(); n++; end
    chk("t2_first", 64'(valid), 64'h1);
    stall_i = 1'b1;
    repeat (8) tick();
    chk("t2_cyc_full_a", 64'(bus_cyc), 64'h0);
    repeat (2) tick();
    chk("t2_cyc_full_b", 64'(bus_cyc), 64'h0);
    chk("t2_pc_held", 64'(pc), 64'h0);
    stall_i = 1'b0;
    drain("t2_drain");

    // redirect while the 0x0C read waits for its ack
    hold_reset();
    slow_adr = 32'hC;
    slow_lat = 3;
    stall_i = 1'b1;
    push_s(32'h0);
    rst_i = 1'b1;
    n = 0;
    while (!(bus_cyc && bus_adr == 32'hC) && n < 30) begin
      tick(); n++;
    end
    chk("t3_req_c", 64'(bus_cyc && bus_adr == 32'hC), 64'h1);
    chk("t3_pre", 64'(sb_q.size()), 64'h0);
    i0 = acks.size();
    pc_set = 1'b1;
    pc_in = 32'h100;
    push_s(32'h100);
    push_s(32'h104);
    push_s(32'h108);
    tick();
    pc_set = 1'b0;
    chk("t3_valid0", 64'(valid), 64'h0);
    chk("t3_ir0", ir, 64'h0);
    chk("t3_cyc_held", 64'(bus_cyc), 64'h1);
    chk("t3_adr_held", 64'(bus_adr), 64'hC);
    n = 0;
    while (!valid && n < 30) begin tick(); n++; end
    stall_i = 1'b0;
    drain("t3_drain");
    chk("t3_ack0", 64'(ack_at(i0)), 64'hC);
    chk("t3_ack1", 64'(ack_at(i0 + 1)), 64'h100);

    // redirect in the same cycle as an ack, misaligned target
    hold_reset();
    stall_i = 1'b1;
    push_s(32'h0);
    rst_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!(bus_ack && bus_adr == 32'h8) && n < 30);
    chk("t4_ack8", 64'(bus_ack && bus_adr == 32'h8), 64'h1);
    i0 = acks.size();
    pc_set = 1'b1;
    pc_in = 32'h203;
    push_s(32'h200);
    push_s(32'h204);
    push_s(32'h208);
    tick();
    pc_set = 1'b0;
    chk("t4_valid0", 64'(valid), 64'h0);
    n = 0;
    while (!valid && n < 30) begin tick(); n++; end
    stall_i = 1'b0;
    drain("t4_drain");
    chk("t4_ack0", 64'(ack_at(i0)), 64'h8);
    chk("t4_ack1", 64'(ack_at(i0 + 1)), 64'h200);

    // long insn whose extension word is slow
    hold_reset();
    mem[32'h4] = 32'h0000_ABC1;
    mem[32'h8] = 32'hCAFE_F00D;
    slow_adr = 32'h8;
    slow_lat = 5;
    push_s(32'h0);
    push(32'h4, 64'hCAFE_F00D_0000_ABC1);
    push_s(32'hC);
    push_s(32'h10);
    rst_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!(bus_ack && bus_adr == 32'h8) && n < 40);
    chk("t5_ack8", 64'(bus_ack && bus_adr == 32'h8), 64'h1);
    chk("t5_wait_a", 64'(valid), 64'h0);
    tick();
    chk("t5_wait_b", 64'(valid), 64'h0);
    drain("t5_drain");

    // asynchronous reset in the middle of a transfer
    hold_reset();
    slow_adr = 32'h4;
    slow_lat = 5;
    push_s(32'h0);
    rst_i = 1'b1;
    n = 0;
    while (!(bus_cyc && bus_adr == 32'h4) && n < 30) begin
      tick(); n++;
    end
    tick();
    chk("t6_pre", 64'(sb_q.size()), 64'h0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_cyc", 64'(bus_cyc), 64'h0);
    chk("t6_valid", 64'(valid), 64'h0);
    chk("t6_ir", ir, 64'h0);
    chk("t6_pc", 64'(pc), 64'h0);
    tick();
    tick();
    i0 = acks.size();
    push_s(32'h0);
    push_s(32'h4);
    push_s(32'h8);
    rst_i = 1'b1;
    drain("t6_drain");
    chk("t6_restart", 64'(ack_at(i0)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
